adder_accumulate_ctrl: RTL

Sequencing and accumulator stage that wraps the 16-bit combinational adder. It sits directly upstream and downstream of the adder. On each debounced Run press it drives the adder's A/B/carry-in from the accumulator and switch operand. It holds them stable for a programmable settle window so the full ripple path resolves, then captures the sum and carry back into the accumulator. Outputs feed the hex display and LED logic.

---
 rtl/adder_ctrl_pkg.sv | 5 +
 rtl/sync_edge.sv | 18 +
 rtl/adder_accumulate_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared types for the adder sequencing/accumulate stage.
package adder_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, HOLD} state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an async button level, plus a history flop for rise detect.
module sync_edge (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d,
  output logic level,
  output logic rise
);
  logic [2:0] sh;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) sh <= '0;
    else          sh <= {sh[1:0], d};
  end

  assign level = sh[1];
  assign rise  = sh[1] & ~sh[2];
endmodule

// File: rtl/adder_accumulate_ctrl.sv
// Drives an external ripple adder from the accumulator and switches, waits a settle
// window with the operands frozen, then captures sum/carry back into the accumulator.
module adder_accumulate_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             Clear,
  input  logic             Sub,
  input  logic [WIDTH-1:0] Sw,
  output logic [WIDTH-1:0] Adder_A,
  output logic [WIDTH-1:0] Adder_B,
  output logic             Adder_Cin,
  input  logic [WIDTH-1:0] Adder_S,
  input  logic             Adder_Cout,
  output logic [WIDTH-1:0] Acc,
  output logic             Carry,
  output logic             Busy,
  output logic             Done
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             run_lvl, run_rise, clr_lvl, clear_rise_unused;

  sync_edge u_run (.Clk(Clk), .Reset_n(Reset_n), .d(Run),   .level(run_lvl), .rise(run_rise));
  sync_edge u_clr (.Clk(Clk), .Reset_n(Reset_n), .d(Clear), .level(clr_lvl), .rise(clear_rise_unused));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      Adder_A   <= '0;
      Adder_B   <= '0;
      Adder_Cin <= 1'b0;
      Acc       <= '0;
      Carry     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else if (clr_lvl) begin
      // Clear overrides everything, including a run edge seen this same cycle.
      state     <= run_lvl ? HOLD : IDLE;
      cnt       <= '0;
      Adder_A   <= '0;
      Adder_B   <= '0;
      Adder_Cin <= 1'b0;
      Acc       <= '0;
      Carry     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (run_rise) begin
          // Operands are only ever loaded here, so they stay frozen through WAIT+CAPTURE.
          Adder_A   <= Acc;
          Adder_B   <= Sub ? ~Sw : Sw;
          Adder_Cin <= Sub;
          cnt       <= CNT_W'(SETTLE_CYCLES - 1);
          Busy      <= 1'b1;
          state     <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          Done  <= 1'b1;
          state <= CAPTURE;
        end else begin
          cnt <= cnt - 1'b1;
        end
        CAPTURE: begin
          Acc   <= Adder_S;
          Carry <= Adder_Cout;
          Busy  <= 1'b0;
          state <= HOLD;
        end
        HOLD: if (!run_lvl) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
